// File: rtl/ibuf_predecode.sv
// Instruction parcel buffer with predecode between fetch and the 16-bit decoder.
// A fetch word is split into 16-bit parcels that are queued with their PCs in a
// DEPTH-entry FIFO. The head parcel, its PC and its predecode class are presented
// from registers, so they are stable while the decoder stalls.
// Optional feature macro: IBUF_BYPASS_EN. When it is defined, a push into an empty
// buffer presents parcel fetch_skip combinationally in the same cycle.
module ibuf_predecode #(
    parameter int unsigned RV    = 32,
    parameter int unsigned FW    = 32,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned NP   = FW / 16,
    localparam int unsigned SW   = (NP > 1) ? $clog2(NP) : 1,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          fetch_valid,
    output logic          fetch_ready,
    input  logic [FW-1:0] fetch_data,
    input  logic [SW-1:0] fetch_skip,
    input  logic [RV-1:0] fetch_pc,
    output logic          ins_valid,
    input  logic          ins_ready,
    output logic [15:0]   ins,
    output logic [RV-1:0] ins_pc,
    output logic          pd_br,
    output logic          pd_jmp,
    output logic          pd_mem,
    output logic          pd_sys,
    output logic          pd_ill,
    output logic [LW-1:0] level
);

    // Predecode of one parcel, packed as {br, jmp, mem, sys, ill}.
    function automatic logic [4:0] predecode(input logic [15:0] p);
        logic [1:0] q;
        logic [2:0] f;
        logic       br;
        logic       jmp;
        logic       mem;
        logic       sys;
        logic       ill;
        q   = p[1:0];
        f   = p[15:13];
        br  = ((q == 2'b01) && ((f == 3'b001) || (f == 3'b101) ||
                                (f == 3'b110) || (f == 3'b111))) ||
              ((q == 2'b11) && ((f == 3'b110) || (f == 3'b111)));
        jmp = (q == 2'b10) && (f == 3'b100) && (p[6:2] == 5'd0);
        mem = (((q == 2'b00) || (q == 2'b10)) &&
               ((f == 3'b010) || (f == 3'b011) || (f == 3'b110) || (f == 3'b111))) ||
              ((q == 2'b11) && ((f == 3'b001) || (f == 3'b010) || (f == 3'b101)));
        sys = (q == 2'b11) && (f == 3'b000);
        ill = (p == 16'h0000) ||
              ((q == 2'b00) && ((f == 3'b001) || (f == 3'b100) || (f == 3'b101)));
        return {br, jmp, mem, sys, ill};
    endfunction

    // State
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ins_valid_q, ins_valid_d;
    logic [15:0]   ins_q, ins_d;
    logic [RV-1:0] ins_pc_q, ins_pc_d;
    logic [4:0]    pd_q, pd_d;

    // Parcel storage (not reset)
    logic [15:0]   mem_q [DEPTH];
    logic [RV-1:0] pcm_q [DEPTH];

    // Combinational helpers
    logic [15:0]   parcel_c [NP];
    logic          wen_c    [DEPTH];
    logic [15:0]   wdat_c   [DEPTH];
    logic [RV-1:0] wpc_c    [DEPTH];
    logic          push_c;
    logic          skip_ok_c;
    logic          byp_c;
    logic          byp_take_c;
    logic          pop_c;
    logic          fifo_pop_c;
    logic [31:0]   w_cnt_c;
    logic [31:0]   w_src_c;
    logic [RV-1:0] w_pc_c;

    // Split the fetch word into parcels, parcel 0 in the low bits.
    always_comb begin
        for (int i = 0; i < int'(NP); i++) begin
            parcel_c[i] = fetch_data[i*16 +: 16];
        end
    end

    // Handshake decode: accept, pop, and the optional same-cycle bypass.
    always_comb begin
        fetch_ready = (level_q <= LW'(DEPTH - NP));
        skip_ok_c   = (32'(fetch_skip) < NP);
        push_c      = fetch_valid & fetch_ready & ~flush;
`ifdef IBUF_BYPASS_EN
        byp_c       = push_c & skip_ok_c & (level_q == '0);
`else
        byp_c       = 1'b0;
`endif
        pop_c       = (ins_valid_q | byp_c) & ins_ready & ~flush;
        byp_take_c  = byp_c & pop_c;
        fifo_pop_c  = pop_c & ~byp_c;
        w_cnt_c     = '0;
        w_src_c     = 32'(fetch_skip) + 32'(byp_take_c);
        w_pc_c      = fetch_pc + (byp_take_c ? RV'(2) : RV'(0));
        if (push_c && skip_ok_c) begin
            w_cnt_c = NP - 32'(fetch_skip) - 32'(byp_take_c);
        end
    end

    // Per-slot write enables: slots wr_ptr .. wr_ptr+w_cnt-1 take consecutive parcels.
    always_comb begin
        for (int s = 0; s < int'(DEPTH); s++) begin
            logic [AW-1:0] off;
            logic [31:0]   src;
            off       = AW'(s) - wr_ptr_q;
            src       = w_src_c + 32'(off);
            wen_c[s]  = (32'(off) < w_cnt_c);
            wdat_c[s] = 16'h0000;
            wpc_c[s]  = w_pc_c + (RV'(off) << 1);
            if (wen_c[s]) begin
                wdat_c[s] = parcel_c[SW'(src)];
            end
        end
    end

    // Next pointers, level and registered head (head may be a parcel written this cycle).
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        level_d     = level_q;
        ins_valid_d = ins_valid_q;
        ins_d       = ins_q;
        ins_pc_d    = ins_pc_q;
        pd_d        = pd_q;
        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            level_d     = '0;
            ins_valid_d = 1'b0;
        end else begin
            rd_ptr_d    = rd_ptr_q + AW'(fifo_pop_c);
            wr_ptr_d    = wr_ptr_q + AW'(w_cnt_c);
            level_d     = LW'(32'(level_q) + w_cnt_c - 32'(fifo_pop_c));
            ins_valid_d = (level_d != '0);
            if (ins_valid_d) begin
                if (wen_c[rd_ptr_d]) begin
                    ins_d    = wdat_c[rd_ptr_d];
                    ins_pc_d = wpc_c[rd_ptr_d];
                end else begin
                    ins_d    = mem_q[rd_ptr_d];
                    ins_pc_d = pcm_q[rd_ptr_d];
                end
                pd_d = predecode(ins_d);
            end
        end
    end

    // Control and head registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            ins_valid_q <= 1'b0;
            ins_q       <= '0;
            ins_pc_q    <= '0;
            pd_q        <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            ins_valid_q <= ins_valid_d;
            ins_q       <= ins_d;
            ins_pc_q    <= ins_pc_d;
            pd_q        <= pd_d;
        end
    end

    // Parcel and PC storage writes.
    always_ff @(posedge clk) begin
        for (int s = 0; s < int'(DEPTH); s++) begin
            if (wen_c[s]) begin
                mem_q[s] <= wdat_c[s];
                pcm_q[s] <= wpc_c[s];
            end
        end
    end

    // A skip of a whole fetch word or more is never legal.
    skip_legal_a: assert property (@(posedge clk) disable iff (!reset_n)
                                   push_c |-> skip_ok_c);

    // Output drive; bypass overrides the registered head while the buffer is empty.
`ifdef IBUF_BYPASS_EN
    logic [15:0] byp_par_c;
    logic [4:0]  byp_pd_c;
    always_comb begin
        byp_par_c = parcel_c[fetch_skip];
        byp_pd_c  = predecode(byp_par_c);
        ins       = byp_c ? byp_par_c : ins_q;
        ins_pc    = byp_c ? fetch_pc  : ins_pc_q;
        {pd_br, pd_jmp, pd_mem, pd_sys, pd_ill} = byp_c ? byp_pd_c : pd_q;
    end
`else
    always_comb begin
        ins    = ins_q;
        ins_pc = ins_pc_q;
        {pd_br, pd_jmp, pd_mem, pd_sys, pd_ill} = pd_q;
    end
`endif

    assign ins_valid = ins_valid_q | byp_c;
    assign level     = level_q;

endmodule

// File: tb/tb_ibuf_predecode.sv
// Scoreboard bench for ibuf_predecode at FW=32, DEPTH=8, RV=32 (bypass disabled).
module tb_ibuf_predecode;

    localparam int unsigned RV    = 32;
    localparam int unsigned FW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned NP    = FW / 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          fetch_valid;
    logic          fetch_ready;
    logic [FW-1:0] fetch_data;
    logic [0:0]    fetch_skip;
    logic [RV-1:0] fetch_pc;
    logic          ins_valid;
    logic          ins_ready;
    logic [15:0]   ins;
    logic [RV-1:0] ins_pc;
    logic          pd_br, pd_jmp, pd_mem, pd_sys, pd_ill;
    logic [3:0]    level;

    typedef struct {
        logic [15:0] p;
        logic [31:0] pc;
    } ent_t;

    ent_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ibuf_predecode #(.RV(RV), .FW(FW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_data(fetch_data), .fetch_skip(fetch_skip), .fetch_pc(fetch_pc),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins), .ins_pc(ins_pc),
        .pd_br(pd_br), .pd_jmp(pd_jmp), .pd_mem(pd_mem), .pd_sys(pd_sys),
        .pd_ill(pd_ill), .level(level)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference class decode written from the opcode tables: {br,jmp,mem,sys,ill}.
    function automatic logic [4:0] ref_pd(input logic [15:0] p);
        int q;
        int f;
        logic br, jmp, mem, sys, ill;
        q   = int'(p[1:0]);
        f   = int'(p[15:13]);
        br  = (q == 1 && f inside {1, 5, 6, 7}) || (q == 3 && f inside {6, 7});
        jmp = (q == 2 && f == 4 && p[6:2] == 5'd0);
        mem = (q inside {0, 2} && f inside {2, 3, 6, 7}) || (q == 3 && f inside {1, 2, 5});
        sys = (q == 3 && f == 0);
        ill = (p == 16'h0) || (q == 0 && f inside {1, 4, 5});
        return {br, jmp, mem, sys, ill};
    endfunction

    // One clock: drive, check against the model at negedge, then advance the model.
    task automatic step(input logic fv, input logic [31:0] data, input int skip,
                        input logic [31:0] pc, input logic rdy, input logic fl);
        logic exp_rdy;
        fetch_valid = fv;
        fetch_data  = data;
        fetch_skip  = 1'(skip);
        fetch_pc    = pc;
        ins_ready   = rdy;
        flush       = fl;
        @(negedge clk);
        exp_rdy = ((int'(DEPTH) - sb.size()) >= int'(NP));
        chk("valid", 64'(ins_valid), 64'(sb.size() != 0));
        chk("level", 64'(level), 64'(sb.size()));
        chk("ready", 64'(fetch_ready), 64'(exp_rdy));
        if (sb.size() != 0) begin
            chk("ins", 64'(ins), 64'(sb[0].p));
            chk("pc", 64'(ins_pc), 64'(sb[0].pc));
            chk("pd", 64'({pd_br, pd_jmp, pd_mem, pd_sys, pd_ill}), 64'(ref_pd(sb[0].p)));
        end
        if (fl) begin
            sb.delete();
        end else begin
            if (sb.size() != 0 && rdy) void'(sb.pop_front());
            if (fv && exp_rdy) begin
                for (int i = skip; i < int'(NP); i++) begin
                    ent_t e;
                    e.p  = data[i*16 +: 16];
                    e.pc = pc + 32'(2 * (i - skip));
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 0, 32'h0, rdy, 1'b0);
    endtask

    initial begin
        logic [31:0] pcw;
        reset_n     = 1'b0;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        fetch_data  = '0;
        fetch_skip  = '0;
        fetch_pc    = '0;
        ins_ready   = 1'b0;
        #12;
        chk("rst_valid", 64'(ins_valid), 64'd0);
        chk("rst_ready", 64'(fetch_ready), 64'd1);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ins", 64'(ins), 64'd0);
        chk("rst_pc", 64'(ins_pc), 64'd0);
        chk("rst_pd", 64'({pd_br, pd_jmp, pd_mem, pd_sys, pd_ill}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic push, then two pops.
        step(1'b1, 32'h0505_8082, 0, 32'h100, 1'b0, 1'b0);
        chk("t1_ins", 64'(ins), 64'h8082);
        chk("t1_pc", 64'(ins_pc), 64'h100);
        chk("t1_jmp", 64'(pd_jmp), 64'd1);
        step(1'b0, 32'h0, 0, 32'h0, 1'b1, 1'b0);
        chk("t1b_ins", 64'(ins), 64'h0505);
        chk("t1b_pc", 64'(ins_pc), 64'h102);
        chk("t1b_br", 64'(pd_br), 64'd0);
        chk("t1b_ill", 64'(pd_ill), 64'd0);
        idle(1'b1, 2);

        // Mid-word skip: only the upper parcel is queued.
        step(1'b1, 32'h0505_8082, 1, 32'h202, 1'b0, 1'b0);
        chk("skip_ins", 64'(ins), 64'h0505);
        chk("skip_pc", 64'(ins_pc), 64'h202);
        chk("skip_lvl", 64'(level), 64'd1);
        step(1'b0, 32'h0, 0, 32'h0, 1'b1, 1'b0);
        chk("skip_lvl0", 64'(level), 64'd0);

        // Fill to full; the fifth word is refused.
        for (int i = 0; i < 5; i++)
            step(1'b1, $urandom, 0, 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
        chk("full_lvl", 64'(level), 64'd8);
        chk("full_rdy", 64'(fetch_ready), 64'd0);
        idle(1'b1, 2);
        chk("fill_rdy", 64'(fetch_ready), 64'd1);
        idle(1'b1, 7);

        // Flush with a simultaneous push at level 5.
        for (int i = 0; i < 3; i++)
            step(1'b1, $urandom, 0, 32'h2000 + 32'(4 * i), 1'b0, 1'b0);
        idle(1'b1, 1);
        chk("pre_fl_lvl", 64'(level), 64'd5);
        step(1'b1, 32'h1111_2222, 0, 32'h3000, 1'b1, 1'b1);
        chk("fl_lvl", 64'(level), 64'd0);
        chk("fl_valid", 64'(ins_valid), 64'd0);
        idle(1'b0, 2);

        // Backpressure: head held for ten cycles.
        step(1'b1, 32'h6001_4502, 0, 32'h400, 1'b0, 1'b0);
        idle(1'b0, 10);
        chk("bp_ins", 64'(ins), 64'h4502);
        chk("bp_pc", 64'(ins_pc), 64'h400);
        idle(1'b1, 3);

        // Streaming at one word per two cycles across the PC wrap.
        pcw = 32'hFFFF_FFF4;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                step(1'b1, $urandom, 0, pcw, 1'b1, 1'b0);
                pcw = pcw + 32'd4;
            end else begin
                step(1'b0, 32'h0, 0, 32'h0, 1'b1, 1'b0);
            end
            chk("stream_lvl", 64'(level <= 4'd2), 64'd1);
        end
        idle(1'b1, 3);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rpc;
            rpc = {$urandom, 1'b0};
            step(1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 1)), rpc,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
        end
        idle(1'b1, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
